acq_trigger_ctrl: RTL and testbench

Acquisition/trigger controller for the digital storage oscilloscope frame RAM. It sequences writes into the shared dual-port frame buffer: a pre-trigger fill, a level/slope trigger search on channel A, a post-trigger fill, then a freeze while the display sweeps the frozen frame. It also produces the display read base address from the trigger position and the left/right pan keys. It sits between the ADC sample strobe and the frame RAM write port, and replaces the free-running write addressing.

---
 rtl/acq_trigger_ctrl_if.sv | 10 +
 rtl/acq_trigger_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_acq_trigger_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_trigger_ctrl_if.sv
// Sample stream in, frame RAM write port out, for the acquisition/trigger controller.
interface acq_trigger_ctrl_if;
  logic       sample_en;
  logic [7:0] adc_a;
  logic       wr_en;
  logic [8:0] wr_addr;

  modport master (output sample_en, output adc_a, input  wr_en, input  wr_addr);
  modport slave  (input  sample_en, input  adc_a, output wr_en, output wr_addr);
endinterface

// File: rtl/acq_trigger_ctrl.sv
// Oscilloscope acquisition sequencer: pre-trigger fill, trigger search, post fill, hold,
// plus the pan-adjusted display base address derived from the trigger position.
module acq_trigger_ctrl #(
  parameter int unsigned DEPTH        = 400,
  parameter int unsigned PRE          = 100,
  parameter int unsigned FRAME        = 200,
  parameter int unsigned STEP         = 10,
  parameter int unsigned AUTO_TIMEOUT = 1000,
  parameter int unsigned HOLD_SAMPLES = 400
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  acq_trigger_ctrl_if.slave      bus,
  input  logic [7:0]             trig_level,
  input  logic                   trig_slope,
  input  logic [1:0]             trig_mode,
  input  logic                   arm,
  input  logic                   key_left,
  input  logic                   key_right,
  output logic [8:0]             view_base,
  output logic                   triggered,
  output logic                   frame_done,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRETRIG = 3'd1,
    ARMED   = 3'd2,
    POST    = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam int unsigned M1      = (PRE > DEPTH) ? PRE : DEPTH;
  localparam int unsigned M2      = (AUTO_TIMEOUT > HOLD_SAMPLES) ? AUTO_TIMEOUT : HOLD_SAMPLES;
  localparam int unsigned CNT_MAX = (M1 > M2) ? M1 : M2;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE - 1);
  localparam logic [CW-1:0] AUTO_LAST = CW'(AUTO_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_SAMPLES - 1);
  localparam logic [CW-1:0] POST_LOAD = CW'(DEPTH - PRE - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  localparam logic [8:0] LAST_ADDR = 9'(DEPTH - 1);

  localparam int unsigned OFF_MAX   = DEPTH - FRAME;
  localparam int unsigned OFF_PRE   = (PRE > FRAME / 2) ? PRE - FRAME / 2 : 0;
  localparam int unsigned OFF_RST   = (OFF_PRE > OFF_MAX) ? OFF_MAX : OFF_PRE;
  localparam int unsigned VB_RST    = (DEPTH - PRE + OFF_RST) % DEPTH;

  localparam logic [9:0] OFF_MAX10 = 10'(OFF_MAX);
  localparam logic [9:0] STEP10    = 10'(STEP);
  localparam logic [9:0] DEPTH10   = 10'(DEPTH);
  localparam logic [9:0] VB_BIAS   = 10'(DEPTH - PRE);

  state_t      st;
  logic [CW-1:0] cnt;
  logic [8:0]  ptr;
  logic [8:0]  trig_addr;
  logic [7:0]  prev;
  logic        prev_valid;
  logic        forced;
  logic [8:0]  offset;

  logic        mode_single;
  logic        mode_auto;
  logic        writing;
  logic        trig_hit;
  logic        force_hit;
  logic [8:0]  ptr_next;
  logic [9:0]  off_up;
  logic [8:0]  off_next;
  logic [9:0]  vb_sum;
  logic [9:0]  vb_s1;
  logic [9:0]  vb_s2;

  assign mode_single = (trig_mode == 2'd2);
  assign mode_auto   = (trig_mode == 2'd0);
  assign writing     = (st == PRETRIG) || (st == ARMED) || (st == POST);
  assign bus.wr_en   = rst_n && bus.sample_en && writing;
  assign bus.wr_addr = ptr;
  assign state       = st;
  assign ptr_next    = (ptr == LAST_ADDR) ? '0 : ptr + 9'd1;

  always_comb begin
    trig_hit = 1'b0;
    if (prev_valid) begin
      if (trig_slope) trig_hit = (prev < trig_level) && (bus.adc_a >= trig_level);
      else            trig_hit = (prev > trig_level) && (bus.adc_a <= trig_level);
    end
  end

  assign force_hit = mode_auto && (cnt == AUTO_LAST);

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      st         <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      trig_addr  <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      forced     <= 1'b0;
      triggered  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (bus.sample_en) begin
        prev       <= bus.adc_a;
        prev_valid <= 1'b1;
      end
      if (bus.wr_en) ptr <= ptr_next;

      unique case (st)
        IDLE: begin
          if (!mode_single || arm) begin
            st  <= PRETRIG;
            cnt <= '0;
          end
        end
        PRETRIG: begin
          if (bus.sample_en) begin
            if (cnt == PRE_LAST) begin
              st  <= ARMED;
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        ARMED: begin
          if (bus.sample_en) begin
            if (trig_hit || force_hit) begin
              st        <= POST;
              cnt       <= POST_LOAD;
              trig_addr <= ptr;
              forced    <= !trig_hit;
            end else if (cnt != AUTO_LAST) begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        POST: begin
          if (bus.sample_en) begin
            if (cnt == CNT_ONE) begin
              st         <= HOLD;
              cnt        <= '0;
              triggered  <= !forced;
              frame_done <= 1'b1;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
        end
        HOLD: begin
          // Single mode leaves HOLD only on arm, which acts without a sample strobe.
          if (mode_single) begin
            if (arm) begin
              st  <= PRETRIG;
              cnt <= '0;
            end
          end else if (bus.sample_en) begin
            if (cnt >= HOLD_LAST) begin
              st  <= PRETRIG;
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  always_comb begin
    off_up   = {1'b0, offset} + STEP10;
    off_next = offset;
    if (key_right && !key_left)
      off_next = (off_up > OFF_MAX10) ? 9'(OFF_MAX10) : 9'(off_up);
    else if (key_left && !key_right)
      off_next = ({1'b0, offset} >= STEP10) ? 9'({1'b0, offset} - STEP10) : '0;
  end

  // Sum stays below 3*DEPTH, so two conditional subtracts complete the modulo.
  always_comb begin
    vb_sum = {1'b0, trig_addr} + VB_BIAS + {1'b0, offset};
    vb_s1  = (vb_sum >= DEPTH10) ? vb_sum - DEPTH10 : vb_sum;
    vb_s2  = (vb_s1 >= DEPTH10) ? vb_s1 - DEPTH10 : vb_s1;
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      offset    <= 9'(OFF_RST);
      view_base <= 9'(VB_RST);
    end else begin
      offset    <= off_next;
      view_base <= vb_s2[8:0];
    end
  end

endmodule

// File: tb/tb_acq_trigger_ctrl.sv
// Directed self-checking bench for acq_trigger_ctrl with hand-computed frame addresses.
module tb_acq_trigger_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] trig_level;
  logic       trig_slope;
  logic [1:0] trig_mode;
  logic       arm;
  logic       key_left;
  logic       key_right;
  logic [8:0] view_base;
  logic       triggered;
  logic       frame_done;
  logic [2:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  acq_trigger_ctrl_if bus ();

  acq_trigger_ctrl #(
    .DEPTH(400), .PRE(100), .FRAME(200), .STEP(10),
    .AUTO_TIMEOUT(1000), .HOLD_SAMPLES(400)
  ) dut (
    .sys_clk(clk), .rst_n(rst_n), .bus(bus),
    .trig_level(trig_level), .trig_slope(trig_slope), .trig_mode(trig_mode),
    .arm(arm), .key_left(key_left), .key_right(key_right),
    .view_base(view_base), .triggered(triggered), .frame_done(frame_done),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // One strobe; write port observed mid-cycle, returns at posedge+1.
  task automatic do_sample(input logic [7:0] v, output logic we, output logic [8:0] wa);
    bus.sample_en = 1'b1;
    bus.adc_a     = v;
    #2;
    we = bus.wr_en;
    wa = bus.wr_addr;
    @(posedge clk); #1;
    bus.sample_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; trig_mode = 2'd1; bus.sample_en = 1'b1; bus.adc_a = 8'd0;
    tick(2);
    if (state !== 3'd0) begin $display("FAIL reset_state: got %0d want 0", state); n_bad++; end n_cmp++;
    if (bus.wr_en !== 1'b0) begin $display("FAIL reset_wr_en: got %0b want 0", bus.wr_en); n_bad++; end n_cmp++;
    if (bus.wr_addr !== 9'd0) begin $display("FAIL reset_wr_addr: got %0d want 0", bus.wr_addr); n_bad++; end n_cmp++;
    if (view_base !== 9'd300) begin $display("FAIL reset_view_base: got %0d want 300", view_base); n_bad++; end n_cmp++;
    if (triggered !== 1'b0) begin $display("FAIL reset_triggered: got %0b want 0", triggered); n_bad++; end n_cmp++;
    if (frame_done !== 1'b0) begin $display("FAIL reset_frame_done: got %0b want 0", frame_done); n_bad++; end n_cmp++;
    bus.sample_en = 1'b0; rst_n = 1'b1;
    #2;
    if (state !== 3'd0) begin $display("FAIL release_idle: got %0d want 0", state); n_bad++; end n_cmp++;
    @(posedge clk); #1;
    if (state !== 3'd1) begin $display("FAIL idle_exit: got %0d want 1", state); n_bad++; end n_cmp++;
  endtask

  task automatic test_normal;
    logic we; logic [8:0] wa;
    trig_level = 8'd128; trig_slope = 1'b1;
    for (int k = 0; k < 428; k++) begin
      do_sample(8'(k), we, wa);
      if (we !== 1'b1 || wa !== 9'(k % 400)) begin
        $display("FAIL normal_write k=%0d: got en=%0b addr=%0d want en=1 addr=%0d", k, we, wa, k % 400); n_bad++;
      end
      n_cmp++;
      if (k == 99 || k == 127) begin
        if (state !== 3'd2) begin $display("FAIL normal_armed k=%0d: got %0d want 2", k, state); n_bad++; end n_cmp++;
      end
      if (k == 128) begin
        if (state !== 3'd3) begin $display("FAIL normal_post: got %0d want 3", state); n_bad++; end n_cmp++;
      end
      if (k == 426) begin
        if (state !== 3'd3 || frame_done !== 1'b0) begin
          $display("FAIL normal_pre_end: got state=%0d fd=%0b want 3/0", state, frame_done); n_bad++;
        end
        n_cmp++;
      end
    end
    if (state !== 3'd4) begin $display("FAIL normal_hold: got %0d want 4", state); n_bad++; end n_cmp++;
    if (frame_done !== 1'b1) begin $display("FAIL normal_frame_done: got %0b want 1", frame_done); n_bad++; end n_cmp++;
    if (triggered !== 1'b1) begin $display("FAIL normal_triggered: got %0b want 1", triggered); n_bad++; end n_cmp++;
    if (view_base !== 9'd28) begin $display("FAIL normal_view_base: got %0d want 28", view_base); n_bad++; end n_cmp++;
    tick(1);
    if (frame_done !== 1'b0) begin $display("FAIL frame_done_pulse: got %0b want 0", frame_done); n_bad++; end n_cmp++;
  endtask

  task automatic test_pan;
    key_right = 1'b1; tick(1); key_right = 1'b0;
    if (view_base !== 9'd28) begin $display("FAIL pan_latency1: got %0d want 28", view_base); n_bad++; end n_cmp++;
    tick(1);
    if (view_base !== 9'd38) begin $display("FAIL pan_latency2: got %0d want 38", view_base); n_bad++; end n_cmp++;
    repeat (24) begin key_right = 1'b1; tick(1); key_right = 1'b0; tick(1); end
    tick(1);
    if (view_base !== 9'd228) begin $display("FAIL pan_right_sat: got %0d want 228", view_base); n_bad++; end n_cmp++;
    key_left = 1'b1; key_right = 1'b1; tick(1); key_left = 1'b0; key_right = 1'b0; tick(2);
    if (view_base !== 9'd228) begin $display("FAIL pan_both: got %0d want 228", view_base); n_bad++; end n_cmp++;
    repeat (25) begin key_left = 1'b1; tick(1); key_left = 1'b0; tick(1); end
    tick(1);
    if (view_base !== 9'd28) begin $display("FAIL pan_left_sat: got %0d want 28", view_base); n_bad++; end n_cmp++;
    if (state !== 3'd4) begin $display("FAIL pan_hold: got %0d want 4", state); n_bad++; end n_cmp++;
  endtask

  task automatic test_hold_exit;
    logic we; logic [8:0] wa;
    int writes = 0;
    for (int i = 0; i < 400; i++) begin
      do_sample(8'd50, we, wa);
      if (we) writes++;
      if (i == 398) begin
        if (state !== 3'd4) begin $display("FAIL hold_399: got %0d want 4", state); n_bad++; end n_cmp++;
      end
    end
    if (writes !== 0) begin $display("FAIL hold_writes: got %0d want 0", writes); n_bad++; end n_cmp++;
    if (state !== 3'd1) begin $display("FAIL hold_exit: got %0d want 1", state); n_bad++; end n_cmp++;
    do_sample(8'd50, we, wa);
    if (we !== 1'b1 || wa !== 9'd28) begin
      $display("FAIL hold_resume: got en=%0b addr=%0d want en=1 addr=28", we, wa); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_auto;
    logic we; logic [8:0] wa;
    int bad = 0;
    trig_mode = 2'd0;
    for (int i = 0; i < 99; i++) begin
      do_sample(8'd50, we, wa);
      if (we !== 1'b1 || wa !== 9'(29 + i)) bad++;
    end
    if (state !== 3'd2) begin $display("FAIL auto_armed: got %0d want 2", state); n_bad++; end n_cmp++;
    for (int i = 0; i < 999; i++) begin
      do_sample(8'd50, we, wa);
      if (we !== 1'b1 || wa !== 9'((128 + i) % 400)) bad++;
    end
    if (state !== 3'd2) begin $display("FAIL auto_999: got %0d want 2", state); n_bad++; end n_cmp++;
    do_sample(8'd50, we, wa);
    if (wa !== 9'd327) begin $display("FAIL auto_trig_addr: got %0d want 327", wa); n_bad++; end n_cmp++;
    if (state !== 3'd3) begin $display("FAIL auto_post: got %0d want 3", state); n_bad++; end n_cmp++;
    for (int i = 0; i < 299; i++) begin
      do_sample(8'd50, we, wa);
      if (we !== 1'b1 || wa !== 9'((328 + i) % 400)) bad++;
      if (i == 297) begin
        if (triggered !== 1'b1) begin $display("FAIL auto_trig_held: got %0b want 1", triggered); n_bad++; end n_cmp++;
      end
    end
    if (bad !== 0) begin $display("FAIL auto_writes: got %0d bad writes want 0", bad); n_bad++; end n_cmp++;
    if (state !== 3'd4 || frame_done !== 1'b1) begin
      $display("FAIL auto_hold: got state=%0d fd=%0b want 4/1", state, frame_done); n_bad++;
    end
    n_cmp++;
    if (triggered !== 1'b0) begin $display("FAIL auto_forced: got %0b want 0", triggered); n_bad++; end n_cmp++;
    if (view_base !== 9'd227) begin $display("FAIL auto_view_base: got %0d want 227", view_base); n_bad++; end n_cmp++;
  endtask

  task automatic test_single;
    logic we; logic [8:0] wa;
    int writes = 0;
    int bad = 0;
    rst_n = 1'b0; trig_mode = 2'd2; trig_level = 8'd128; trig_slope = 1'b1;
    tick(1); rst_n = 1'b1; tick(1);
    for (int i = 0; i < 2000; i++) begin
      do_sample(8'd0, we, wa);
      if (we) writes++;
    end
    if (writes !== 0 || state !== 3'd0) begin
      $display("FAIL single_idle: got writes=%0d state=%0d want 0/0", writes, state); n_bad++;
    end
    n_cmp++;
    arm = 1'b1; tick(1); arm = 1'b0;
    if (state !== 3'd1) begin $display("FAIL single_arm: got %0d want 1", state); n_bad++; end n_cmp++;
    for (int k = 0; k < 428; k++) begin
      if (k == 110) arm = 1'b1;
      do_sample(8'(k), we, wa);
      arm = 1'b0;
      if (we !== 1'b1 || wa !== 9'(k % 400)) bad++;
      if (k == 110) begin
        if (state !== 3'd2) begin $display("FAIL single_arm_ignored: got %0d want 2", state); n_bad++; end n_cmp++;
      end
    end
    if (bad !== 0) begin $display("FAIL single_writes: got %0d bad writes want 0", bad); n_bad++; end n_cmp++;
    if (state !== 3'd4 || triggered !== 1'b1 || view_base !== 9'd28) begin
      $display("FAIL single_frame: got state=%0d trig=%0b vb=%0d want 4/1/28", state, triggered, view_base); n_bad++;
    end
    n_cmp++;
    writes = 0;
    for (int i = 0; i < 5000; i++) begin
      do_sample(8'd120, we, wa);
      if (we) writes++;
    end
    if (writes !== 0 || state !== 3'd4) begin
      $display("FAIL single_hold: got writes=%0d state=%0d want 0/4", writes, state); n_bad++;
    end
    n_cmp++;
    arm = 1'b1; tick(1); arm = 1'b0;
    if (state !== 3'd1) begin $display("FAIL single_rearm: got %0d want 1", state); n_bad++; end n_cmp++;
    do_sample(8'd120, we, wa);
    if (we !== 1'b1 || wa !== 9'd28) begin
      $display("FAIL single_resume: got en=%0b addr=%0d want en=1 addr=28", we, wa); n_bad++;
    end
    n_cmp++;
  endtask

  task automatic test_falling;
    logic we; logic [8:0] wa;
    trig_mode = 2'd1; trig_slope = 1'b0; trig_level = 8'd100;
    for (int i = 0; i < 98; i++) do_sample(8'd120, we, wa);
    do_sample(8'd100, we, wa);
    if (wa !== 9'd127 || state !== 3'd2) begin
      $display("FAIL fall_pretrig: got addr=%0d state=%0d want 127/2", wa, state); n_bad++;
    end
    n_cmp++;
    do_sample(8'd99, we, wa);
    if (state !== 3'd2) begin $display("FAIL fall_prev_eq_level: got %0d want 2", state); n_bad++; end n_cmp++;
    do_sample(8'd120, we, wa);
    do_sample(8'd101, we, wa);
    if (state !== 3'd2) begin $display("FAIL fall_101: got %0d want 2", state); n_bad++; end n_cmp++;
    do_sample(8'd100, we, wa);
    if (wa !== 9'd131 || state !== 3'd3) begin
      $display("FAIL fall_trigger: got addr=%0d state=%0d want 131/3", wa, state); n_bad++;
    end
    n_cmp++;
    tick(1);
    if (view_base !== 9'd31) begin $display("FAIL fall_view_base: got %0d want 31", view_base); n_bad++; end n_cmp++;
  endtask

  task automatic test_reset_mid;
    logic we; logic [8:0] wa;
    do_sample(8'd120, we, wa);
    do_sample(8'd120, we, wa);
    if (triggered !== 1'b1) begin $display("FAIL mid_pre_triggered: got %0b want 1", triggered); n_bad++; end n_cmp++;
    rst_n = 1'b0; bus.sample_en = 1'b1; bus.adc_a = 8'd120;
    tick(1);
    if (state !== 3'd0 || bus.wr_en !== 1'b0 || bus.wr_addr !== 9'd0) begin
      $display("FAIL mid_reset_port: got state=%0d en=%0b addr=%0d want 0/0/0", state, bus.wr_en, bus.wr_addr); n_bad++;
    end
    n_cmp++;
    if (view_base !== 9'd300 || triggered !== 1'b0 || frame_done !== 1'b0) begin
      $display("FAIL mid_reset_flags: got vb=%0d trig=%0b fd=%0b want 300/0/0", view_base, triggered, frame_done); n_bad++;
    end
    n_cmp++;
    bus.sample_en = 1'b0; rst_n = 1'b1;
    tick(1);
    if (state !== 3'd1) begin $display("FAIL mid_restart: got %0d want 1", state); n_bad++; end n_cmp++;
    for (int i = 0; i < 100; i++) begin
      do_sample(8'd120, we, wa);
      if (we !== 1'b1 || wa !== 9'(i)) begin
        $display("FAIL mid_fill i=%0d: got en=%0b addr=%0d want en=1 addr=%0d", i, we, wa, i); n_bad++;
      end
      n_cmp++;
      if (i == 98) begin
        if (state !== 3'd1) begin $display("FAIL mid_fill_len: got %0d want 1", state); n_bad++; end n_cmp++;
      end
    end
    if (state !== 3'd2) begin $display("FAIL mid_armed: got %0d want 2", state); n_bad++; end n_cmp++;
  endtask

  initial begin
    rst_n = 1'b0; trig_level = 8'd128; trig_slope = 1'b1; trig_mode = 2'd1;
    arm = 1'b0; key_left = 1'b0; key_right = 1'b0;
    bus.sample_en = 1'b0; bus.adc_a = 8'd0;
    @(posedge clk); #1;
    test_reset;
    test_normal;
    test_pan;
    test_hold_exit;
    test_auto;
    test_single;
    test_falling;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
